// File: rtl/sram_1r1w_be.sv
// 1R1W block SRAM with per-byte write enables, 1- or 2-cycle registered read and read-valid strobe.
// Optional post-reset zero-fill sequencer built when SRAM_CLEAR_ON_RESET_EN is defined.
module sram_1r1w_be #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned SIZE              = 512,
    parameter int unsigned READ_LATENCY      = 1,
    parameter string       READ_DURING_WRITE = "NEW_DATA",
    parameter int unsigned ADDR_WIDTH        = $clog2(SIZE),
    parameter int unsigned NUM_BYTES         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_BYTES-1:0]  write_byte_en,
    input  logic [DATA_WIDTH-1:0] write_data
);

    localparam int unsigned            SIZE_BITS    = ADDR_WIDTH + 1;
    localparam logic [SIZE_BITS-1:0]   SIZE_EXT     = SIZE_BITS'(SIZE);
    localparam bit                     RDW_NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  user_wr;
    logic                  rd_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [NUM_BYTES-1:0]  mem_wbe;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  ready_next;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  stage1_valid;
    logic [DATA_WIDTH-1:0] stage1_data;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Reset dominates: nothing is accepted on an edge where reset is sampled high.
    assign wr_in_range = {1'b0, write_addr} < SIZE_EXT;
    assign rd_in_range = {1'b0, read_addr} < SIZE_EXT;
    assign user_wr     = write_en && ready && !reset && wr_in_range;
    assign rd_fire     = read_en && ready && !reset;

`ifdef SRAM_CLEAR_ON_RESET_EN
    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Clear walks one word per cycle and owns the write port until done.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        mem_we       = user_wr;
        mem_waddr    = write_addr;
        mem_wbe      = write_byte_en;
        mem_wdata    = write_data;
        ready_next   = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we       = !reset;
                mem_waddr    = clr_cnt;
                mem_wbe      = '1;
                mem_wdata    = '0;
                clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == LAST_ADDR) begin
                    state_next   = ST_READY;
                    clr_cnt_next = '0;
                end
            end
            ST_READY: ready_next = 1'b1;
            default:  state_next = ST_CLEAR;
        endcase
    end
`else
    always_comb begin
        mem_we     = user_wr;
        mem_waddr  = write_addr;
        mem_wbe    = write_byte_en;
        mem_wdata  = write_data;
        ready_next = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) ready <= 1'b0;
        else       ready <= ready_next;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(NUM_BYTES); i++) begin
                if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Word sampled at issue; a same-address write is either merged in or made unknown.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[read_addr];
            if (user_wr && (write_addr == read_addr)) begin
                rd_word = RDW_NEW_DATA ? merge_bytes(mem[read_addr], write_data, write_byte_en)
                                       : {DATA_WIDTH{1'bx}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_valid <= 1'b0;
            stage1_data  <= '0;
        end else begin
            stage1_valid <= rd_fire;
            if (rd_fire) stage1_data <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  stage2_valid;
            logic [DATA_WIDTH-1:0] stage2_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage2_valid <= 1'b0;
                    stage2_data  <= '0;
                end else begin
                    stage2_valid <= stage1_valid;
                    if (stage1_valid) stage2_data <= stage1_data;
                end
            end

            assign read_valid = stage2_valid;
            assign read_data  = stage2_data;
        end else begin : g_lat1
            assign read_valid = stage1_valid;
            assign read_data  = stage1_data;
        end
    endgenerate

endmodule
